// File: rtl/projectile_pkg.sv
// Shared definitions for the projectile pool.
//   TRANSPARENT_ENCODING : RGB value meaning "nothing drawn here"
//   COORD_W              : width of signed screen coordinates
//   slot_t               : per-slot state (active flag, top-left x/y)
//   slot_idx_w()         : width of a slot index, never less than 1
package projectile_pkg;

    localparam logic [7:0]  TRANSPARENT_ENCODING = 8'hFF;
    localparam int unsigned COORD_W              = 11;

    typedef struct packed {
        logic                      active;
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } slot_t;

    function automatic int unsigned slot_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: holds active/x/y, applies hit/spawn/move with priority
// hit > spawn > move, and reports whether the current pixel lies in its bracket.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_spawn, i_spawn_x/y: load position and activate (only issued when inactive)
//   i_hit               : deactivate if active
//   i_move              : frame tick, step Y by SPEED_Y and kill off-screen
//   i_pixel_x/y         : current pixel
//   o_active            : slot active flag
//   o_inside            : pixel inside [x,x+W) x [y,y+H) of an active slot
//   o_offset_x/y        : pixel minus slot origin
module projectile_slot
    import projectile_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 4,
    parameter int OBJECT_HEIGHT_Y = 16,
    parameter int SPEED_Y         = -8,
    parameter int SCREEN_TOP      = 0,
    parameter int SCREEN_BOTTOM   = 479
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_spawn,
    input  logic signed [COORD_W-1:0] i_spawn_x,
    input  logic signed [COORD_W-1:0] i_spawn_y,
    input  logic                      i_hit,
    input  logic                      i_move,
    input  logic signed [COORD_W-1:0] i_pixel_x,
    input  logic signed [COORD_W-1:0] i_pixel_y,
    output logic                      o_active,
    output logic                      o_inside,
    output logic signed [COORD_W-1:0] o_offset_x,
    output logic signed [COORD_W-1:0] o_offset_y
);

    localparam logic signed [11:0] SPEED_12  = 12'(SPEED_Y);
    localparam logic signed [12:0] WIDTH_13  = 13'(OBJECT_WIDTH_X);
    localparam logic signed [12:0] HEIGHT_13 = 13'(OBJECT_HEIGHT_Y);
    localparam logic signed [12:0] TOP_13    = 13'(SCREEN_TOP);
    localparam logic signed [12:0] BOTTOM_13 = 13'(SCREEN_BOTTOM);

    slot_t                     r_state;
    logic signed [11:0]        w_moved_y;
    logic signed [12:0]        w_moved_y13;
    logic signed [12:0]        w_moved_bot;
    logic signed [COORD_W-1:0] w_clamped_y;
    logic                      w_kill;
    logic signed [12:0]        w_px, w_py, w_x, w_y;

    // Move in 12 bits so the step cannot wrap; kill decision uses the exact
    // moved value, the stored Y is clamped back into 11-bit range.
    always_comb begin
        w_moved_y   = $signed({r_state.y[COORD_W-1], r_state.y}) + SPEED_12;
        w_moved_y13 = $signed({w_moved_y[11], w_moved_y});
        w_moved_bot = w_moved_y13 + HEIGHT_13;
        w_kill      = (w_moved_bot < TOP_13) || (w_moved_y13 > BOTTOM_13);
        if (w_moved_y > 12'sd1023) begin
            w_clamped_y = 11'sh3FF;
        end else if (w_moved_y < -12'sd1024) begin
            w_clamped_y = 11'sh400;
        end else begin
            w_clamped_y = w_moved_y[COORD_W-1:0];
        end
    end

    always_comb begin
        w_px       = $signed({{2{i_pixel_x[COORD_W-1]}}, i_pixel_x});
        w_py       = $signed({{2{i_pixel_y[COORD_W-1]}}, i_pixel_y});
        w_x        = $signed({{2{r_state.x[COORD_W-1]}}, r_state.x});
        w_y        = $signed({{2{r_state.y[COORD_W-1]}}, r_state.y});
        o_inside   = r_state.active &&
                     (w_px >= w_x) && (w_px < w_x + WIDTH_13) &&
                     (w_py >= w_y) && (w_py < w_y + HEIGHT_13);
        o_offset_x = i_pixel_x - r_state.x;
        o_offset_y = i_pixel_y - r_state.y;
        o_active   = r_state.active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= '0;
        end else if (i_hit && r_state.active) begin
            r_state.active <= 1'b0;
        end else if (i_spawn) begin
            r_state <= '{active: 1'b1, x: i_spawn_x, y: i_spawn_y};
        end else if (i_move && r_state.active) begin
            r_state.active <= !w_kill;
            r_state.y      <= w_clamped_y;
        end
    end

endmodule

// File: rtl/projectile_pool.sv
// Pool of NUM_SLOTS vertically moving projectiles with fire cooldown, hit
// kills and a registered per-pixel draw result (lowest active slot wins).
// Optional macro PROJECTILE_POOL_COLOR_BY_SLOT_EN: tint the drawn colour by
// XORing the low three bits of the drawn slot index into OBJECT_COLOR.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   pixelX, pixelY         : current VGA pixel (signed)
//   startOfFrame           : one-cycle frame tick (moves slots, ticks cooldown)
//   fire, fire_x, fire_y   : spawn request and top-left position
//   fire_ready             : a spawn would be accepted this cycle
//   hit, hit_slot          : kill request for one slot
//   active_mask            : per-slot active flags
//   drawingRequest, RGBout, offsetX, offsetY, drawn_slot : registered pixel result
module projectile_pool
    import projectile_pkg::*;
#(
    parameter int         NUM_SLOTS       = 4,
    parameter int         OBJECT_WIDTH_X  = 4,
    parameter int         OBJECT_HEIGHT_Y = 16,
    parameter logic [7:0] OBJECT_COLOR    = 8'h5b,
    parameter int         SPEED_Y         = -8,
    parameter int         SCREEN_TOP      = 0,
    parameter int         SCREEN_BOTTOM   = 479,
    parameter int         COOLDOWN_FRAMES = 10,
    localparam int        IDX_W           = slot_idx_w(NUM_SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [COORD_W-1:0] pixelX,
    input  logic signed [COORD_W-1:0] pixelY,
    input  logic                      startOfFrame,
    input  logic                      fire,
    input  logic signed [COORD_W-1:0] fire_x,
    input  logic signed [COORD_W-1:0] fire_y,
    output logic                      fire_ready,
    input  logic                      hit,
    input  logic [IDX_W-1:0]          hit_slot,
    output logic [NUM_SLOTS-1:0]      active_mask,
    output logic                      drawingRequest,
    output logic [7:0]                RGBout,
    output logic signed [COORD_W-1:0] offsetX,
    output logic signed [COORD_W-1:0] offsetY,
    output logic [IDX_W-1:0]          drawn_slot
);

    localparam int             CD_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic [NUM_SLOTS-1:0]      w_active, w_inside, w_spawn, w_hit;
    logic signed [COORD_W-1:0] w_off_x [NUM_SLOTS];
    logic signed [COORD_W-1:0] w_off_y [NUM_SLOTS];
    logic                      w_any_free, w_accept, w_sel_valid;
    logic [IDX_W-1:0]          w_alloc_idx, w_sel_idx;
    logic signed [COORD_W-1:0] w_sel_off_x, w_sel_off_y;
    logic [7:0]                w_color;
    logic [CD_W-1:0]           r_cooldown;
    logic                      r_draw;
    logic [7:0]                r_rgb;
    logic signed [COORD_W-1:0] r_off_x, r_off_y;
    logic [IDX_W-1:0]          r_slot;

    // Allocation looks at pre-edge flags, so a slot hit this cycle stays busy.
    always_comb begin
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!w_active[i]) begin
                w_any_free  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
        end
    end

    assign fire_ready  = w_any_free && (r_cooldown == '0);
    assign w_accept    = fire && fire_ready;
    assign active_mask = w_active;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_spawn[i] = w_accept && (w_alloc_idx == IDX_W'(i));
            w_hit[i]   = hit && (hit_slot == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        projectile_slot #(
            .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
            .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y),
            .SPEED_Y        (SPEED_Y),
            .SCREEN_TOP     (SCREEN_TOP),
            .SCREEN_BOTTOM  (SCREEN_BOTTOM)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_spawn   (w_spawn[g]),
            .i_spawn_x (fire_x),
            .i_spawn_y (fire_y),
            .i_hit     (w_hit[g]),
            .i_move    (startOfFrame),
            .i_pixel_x (pixelX),
            .i_pixel_y (pixelY),
            .o_active  (w_active[g]),
            .o_inside  (w_inside[g]),
            .o_offset_x(w_off_x[g]),
            .o_offset_y(w_off_y[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cooldown <= '0;
        end else if (w_accept) begin
            r_cooldown <= CD_LOAD;
        end else if (startOfFrame && (r_cooldown != '0)) begin
            r_cooldown <= r_cooldown - CD_W'(1);
        end
    end

    // Lowest-index containing slot wins the pixel.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_off_x = '0;
        w_sel_off_y = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_inside[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_off_x = w_off_x[i];
                w_sel_off_y = w_off_y[i];
            end
        end
    end

`ifdef PROJECTILE_POOL_COLOR_BY_SLOT_EN
    logic [2:0] w_sel_idx3;
    always_comb begin
        w_sel_idx3            = '0;
        w_sel_idx3[IDX_W-1:0] = w_sel_idx;
    end
    assign w_color = OBJECT_COLOR ^ {5'b0, w_sel_idx3};
`else
    assign w_color = OBJECT_COLOR;
`endif

    always_ff @(posedge clk) begin
        if (reset || !w_sel_valid) begin
            r_draw  <= 1'b0;
            r_rgb   <= TRANSPARENT_ENCODING;
            r_off_x <= '0;
            r_off_y <= '0;
            r_slot  <= '0;
        end else begin
            r_draw  <= 1'b1;
            r_rgb   <= w_color;
            r_off_x <= w_sel_off_x;
            r_off_y <= w_sel_off_y;
            r_slot  <= w_sel_idx;
        end
    end

    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign offsetX        = r_off_x;
    assign offsetY        = r_off_y;
    assign drawn_slot     = r_slot;

endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: two instances (cooldown 10 and cooldown 0) share
// one stimulus stream and are compared with a behavioural pool model.
module tb_projectile_pool;

    localparam int NS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, startOfFrame, fire, hit;
    logic signed [10:0] pixelX, pixelY, fire_x, fire_y;
    logic [1:0]        hit_slot;

    logic [1:0]        rdy, draw;
    logic [1:0][3:0]   mask;
    logic [1:0][7:0]   rgb;
    logic [1:0][10:0]  offx, offy;
    logic [1:0][1:0]   dslot;

    projectile_pool #(.COOLDOWN_FRAMES(10)) u_dut (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ready(rdy[0]), .hit(hit), .hit_slot(hit_slot), .active_mask(mask[0]),
        .drawingRequest(draw[0]), .RGBout(rgb[0]), .offsetX(offx[0]), .offsetY(offy[0]),
        .drawn_slot(dslot[0])
    );

    projectile_pool #(.COOLDOWN_FRAMES(0)) u_dut_nc (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .fire_ready(rdy[1]), .hit(hit), .hit_slot(hit_slot), .active_mask(mask[1]),
        .drawingRequest(draw[1]), .RGBout(rgb[1]), .offsetX(offx[1]), .offsetY(offy[1]),
        .drawn_slot(dslot[1])
    );

    // Reference model: one pool per instance.
    bit         m_act [2][NS];
    int         m_x   [2][NS];
    int         m_y   [2][NS];
    int         m_cd  [2];
    logic       m_draw [2];
    logic [7:0] m_rgb  [2];
    logic [10:0] m_ox  [2];
    logic [10:0] m_oy  [2];
    logic [1:0] m_ds   [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int cd_of(int k);
        return (k == 0) ? 10 : 0;
    endfunction

    function automatic logic [7:0] exp_color(int s);
`ifdef PROJECTILE_POOL_COLOR_BY_SLOT_EN
        return 8'h5b ^ 8'(s);
`else
        return 8'h5b + 8'(s * 0);
`endif
    endfunction

    function automatic bit model_ready(int k);
        if (m_cd[k] != 0) return 1'b0;
        for (int i = 0; i < NS; i++) if (!m_act[k][i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_mask(int k);
        logic [3:0] m;
        for (int i = 0; i < NS; i++) m[i] = m_act[k][i];
        return m;
    endfunction

    task automatic set_idle();
        reset = 1'b0; startOfFrame = 1'b0; fire = 1'b0; hit = 1'b0; hit_slot = 2'd0;
        pixelX = 11'sd0; pixelY = 11'sd0; fire_x = 11'sd0; fire_y = 11'sd0;
    endtask

    // Advance model and DUTs by one clock with the current inputs.
    task automatic step();
        int px, py, fx, fy, sel, alloc, ny;
        bit acc;
        px = pixelX; py = pixelY; fx = fire_x; fy = fire_y;
        for (int k = 0; k < 2; k++) begin
            sel = -1;
            alloc = -1;
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_act[k][i] && px >= m_x[k][i] && px < m_x[k][i] + 4 &&
                    py >= m_y[k][i] && py < m_y[k][i] + 16) sel = i;
                if (!m_act[k][i]) alloc = i;
            end
            acc = fire && model_ready(k);
            if (reset) begin
                for (int i = 0; i < NS; i++) begin
                    m_act[k][i] = 1'b0; m_x[k][i] = 0; m_y[k][i] = 0;
                end
                m_cd[k] = 0;
                m_draw[k] = 1'b0; m_rgb[k] = 8'hFF; m_ox[k] = '0; m_oy[k] = '0; m_ds[k] = '0;
            end else begin
                if (sel >= 0) begin
                    m_draw[k] = 1'b1; m_rgb[k] = exp_color(sel);
                    m_ox[k] = 11'(px - m_x[k][sel]); m_oy[k] = 11'(py - m_y[k][sel]);
                    m_ds[k] = 2'(sel);
                end else begin
                    m_draw[k] = 1'b0; m_rgb[k] = 8'hFF; m_ox[k] = '0; m_oy[k] = '0; m_ds[k] = '0;
                end
                for (int i = 0; i < NS; i++) begin
                    if (hit && int'(hit_slot) == i && m_act[k][i]) begin
                        m_act[k][i] = 1'b0;
                    end else if (acc && i == alloc) begin
                        m_act[k][i] = 1'b1; m_x[k][i] = fx; m_y[k][i] = fy;
                    end else if (startOfFrame && m_act[k][i]) begin
                        ny = m_y[k][i] - 8;
                        if (ny < -1024) ny = -1024;
                        if (ny + 16 < 0 || ny > 479) m_act[k][i] = 1'b0;
                        m_y[k][i] = ny;
                    end
                end
                if (acc) m_cd[k] = cd_of(k);
                else if (startOfFrame && m_cd[k] > 0) m_cd[k] = m_cd[k] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle(); reset = 1'b1; step(); reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle(); reset = 1'b1; step(); step(); reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mask[k] !== 4'b0000) begin
                n_errors++; $display("FAIL reset_mask inst%0d got %b want 0000", k, mask[k]);
            end
            n_checks++;
            if (draw[k] !== 1'b0 || rgb[k] !== 8'hFF || offx[k] !== 11'd0 ||
                offy[k] !== 11'd0 || dslot[k] !== 2'd0) begin
                n_errors++;
                $display("FAIL reset_pixel inst%0d got draw=%b rgb=%h ox=%0d oy=%0d ds=%0d want 0 ff 0 0 0",
                         k, draw[k], rgb[k], offx[k], offy[k], dslot[k]);
            end
            n_checks++;
            if (rdy[k] !== 1'b1) begin
                n_errors++; $display("FAIL reset_ready inst%0d got %b want 1", k, rdy[k]);
            end
        end
    endtask

    task automatic test_fire_cooldown();
        do_reset();
        fire = 1'b1; fire_x = 11'sd100; fire_y = 11'sd400; step(); fire = 1'b0;
        n_checks++;
        if (mask[0] !== 4'b0001) begin
            n_errors++; $display("FAIL fire_slot0 got %b want 0001", mask[0]);
        end
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_errors++; $display("FAIL fire_cooldown_start got %b want 0", rdy[0]);
        end
        for (int f = 1; f <= 10; f++) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step();
            n_checks++;
            if (rdy[0] !== ((f == 10) ? 1'b1 : 1'b0) || rdy[0] !== model_ready(0)) begin
                n_errors++;
                $display("FAIL cooldown_frame%0d got %b want %b", f, rdy[0], (f == 10));
            end
        end
    endtask

    task automatic test_move_draw();
        do_reset();
        fire = 1'b1; fire_x = 11'sd100; fire_y = 11'sd400; step(); fire = 1'b0;
        for (int f = 0; f < 3; f++) begin
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step();
        end
        pixelX = 11'sd101; pixelY = 11'sd380; step();
        n_checks++;
        if (draw[0] !== 1'b1 || offx[0] !== 11'd1 || offy[0] !== 11'd4 ||
            dslot[0] !== 2'd0 || rgb[0] !== 8'h5b) begin
            n_errors++;
            $display("FAIL move_draw got draw=%b ox=%0d oy=%0d ds=%0d rgb=%h want 1 1 4 0 5b",
                     draw[0], offx[0], offy[0], dslot[0], rgb[0]);
        end
        pixelX = 11'sd100; pixelY = 11'sd391; step();
        n_checks++;
        if (draw[0] !== 1'b1 || offx[0] !== 11'd0 || offy[0] !== 11'd15) begin
            n_errors++;
            $display("FAIL draw_bottom_edge got draw=%b ox=%0d oy=%0d want 1 0 15",
                     draw[0], offx[0], offy[0]);
        end
        pixelX = 11'sd104; pixelY = 11'sd380; step();
        n_checks++;
        if (draw[0] !== 1'b0 || rgb[0] !== 8'hFF || offx[0] !== 11'd0) begin
            n_errors++;
            $display("FAIL draw_right_edge got draw=%b rgb=%h ox=%0d want 0 ff 0",
                     draw[0], rgb[0], offx[0]);
        end
        pixelX = 11'sd0; pixelY = 11'sd0;
    endtask

    task automatic test_top_kill();
        logic [3:0] want [3];
        want[0] = 4'b0001; want[1] = 4'b0001; want[2] = 4'b0000;
        do_reset();
        fire = 1'b1; fire_x = 11'sd200; fire_y = 11'sd4; step(); fire = 1'b0;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                pixelX = 11'sd200; pixelY = 11'sd0; step();
                n_checks++;
                if (draw[0] !== 1'b1 || offy[0] !== 11'd12) begin
                    n_errors++;
                    $display("FAIL top_draw got draw=%b oy=%0d want 1 12", draw[0], offy[0]);
                end
                pixelX = 11'sd0;
            end
            startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
            n_checks++;
            if (mask[0] !== want[f]) begin
                n_errors++; $display("FAIL top_kill_frame%0d got %b want %b", f, mask[0], want[f]);
            end
        end
    endtask

    task automatic test_fill_slots();
        logic [3:0] want;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            fire = 1'b1; fire_x = 11'(10 + 20 * n); fire_y = 11'sd200;
            n_checks++;
            if (rdy[1] !== ((n < 4) ? 1'b1 : 1'b0)) begin
                n_errors++; $display("FAIL fill_ready%0d got %b want %b", n, rdy[1], (n < 4));
            end
            step();
            want = 4'((1 << ((n < 4) ? n + 1 : 4)) - 1);
            n_checks++;
            if (mask[1] !== want) begin
                n_errors++; $display("FAIL fill_mask%0d got %b want %b", n, mask[1], want);
            end
        end
        fire = 1'b0;
        n_checks++;
        if (mask[0] !== 4'b0001) begin
            n_errors++; $display("FAIL fill_cooldown_mask got %b want 0001", mask[0]);
        end
    endtask

    task automatic test_hit_collide();
        do_reset();
        fire = 1'b1; fire_x = 11'sd10; fire_y = 11'sd200; step();
        fire_x = 11'sd40; step();
        hit = 1'b1; hit_slot = 2'd1; startOfFrame = 1'b1; fire_x = 11'sd70; fire_y = 11'sd300;
        step();
        set_idle();
        n_checks++;
        if (mask[1] !== 4'b0101) begin
            n_errors++; $display("FAIL collide_mask got %b want 0101", mask[1]);
        end
        n_checks++;
        if (mask[0] !== 4'b0001) begin
            n_errors++; $display("FAIL collide_inactive_hit got %b want 0001", mask[0]);
        end
        pixelX = 11'sd70; pixelY = 11'sd300; step();
        n_checks++;
        if (draw[1] !== 1'b1 || dslot[1] !== 2'd2 || offy[1] !== 11'd0) begin
            n_errors++;
            $display("FAIL collide_new_slot got draw=%b ds=%0d oy=%0d want 1 2 0",
                     draw[1], dslot[1], offy[1]);
        end
        pixelX = 11'sd10; pixelY = 11'sd192; step();
        n_checks++;
        if (draw[1] !== 1'b1 || dslot[1] !== 2'd0 || offy[1] !== 11'd0) begin
            n_errors++;
            $display("FAIL collide_moved_slot0 got draw=%b ds=%0d oy=%0d want 1 0 0",
                     draw[1], dslot[1], offy[1]);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        fire = 1'b1; fire_x = 11'sd300; fire_y = 11'sd100; step();
        fire_x = 11'sd50; fire_y = 11'sd50; step();
        fire_x = 11'sd302; fire_y = 11'sd110; step();
        fire = 1'b0;
        pixelX = 11'sd302; pixelY = 11'sd110; step();
        n_checks++;
        if (draw[1] !== 1'b1 || dslot[1] !== 2'd0 || offx[1] !== 11'd2 ||
            offy[1] !== 11'd10 || rgb[1] !== 8'h5b) begin
            n_errors++;
            $display("FAIL overlap_priority got ds=%0d ox=%0d oy=%0d rgb=%h want 0 2 10 5b",
                     dslot[1], offx[1], offy[1], rgb[1]);
        end
        pixelY = 11'sd120; step();
        n_checks++;
`ifdef PROJECTILE_POOL_COLOR_BY_SLOT_EN
        if (draw[1] !== 1'b1 || dslot[1] !== 2'd2 || offy[1] !== 11'd10 || rgb[1] !== 8'h59) begin
`else
        if (draw[1] !== 1'b1 || dslot[1] !== 2'd2 || offy[1] !== 11'd10 || rgb[1] !== 8'h5b) begin
`endif
            n_errors++;
            $display("FAIL overlap_slot2 got ds=%0d oy=%0d rgb=%h want 2 10 %h",
                     dslot[1], offy[1], rgb[1], exp_color(2));
        end
    endtask

    task automatic test_random();
        int k, i;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            startOfFrame = ($urandom_range(0, 4) == 0);
            fire         = ($urandom_range(0, 2) == 0);
            hit          = ($urandom_range(0, 7) == 0);
            hit_slot     = 2'($urandom_range(0, 3));
            fire_x       = 11'(int'($urandom_range(0, 600)));
            fire_y       = 11'(int'($urandom_range(0, 550)) - 30);
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(0, 1));
                i = int'($urandom_range(0, 3));
                pixelX = 11'(m_x[k][i] + int'($urandom_range(0, 5)) - 1);
                pixelY = 11'(m_y[k][i] + int'($urandom_range(0, 17)) - 1);
            end else begin
                pixelX = 11'(int'($urandom_range(0, 639)));
                pixelY = 11'(int'($urandom_range(0, 479)));
            end
            step();
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (rdy[j] !== model_ready(j) || mask[j] !== model_mask(j)) begin
                    n_errors++;
                    $display("FAIL rand_state c%0d inst%0d got rdy=%b mask=%b want %b %b",
                             c, j, rdy[j], mask[j], model_ready(j), model_mask(j));
                end
                n_checks++;
                if (draw[j] !== m_draw[j] || rgb[j] !== m_rgb[j] || offx[j] !== m_ox[j] ||
                    offy[j] !== m_oy[j] || dslot[j] !== m_ds[j]) begin
                    n_errors++;
                    $display("FAIL rand_pixel c%0d inst%0d got %b %h %0d %0d %0d want %b %h %0d %0d %0d",
                             c, j, draw[j], rgb[j], offx[j], offy[j], dslot[j],
                             m_draw[j], m_rgb[j], m_ox[j], m_oy[j], m_ds[j]);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_fire_cooldown();
        test_move_draw();
        test_top_kill();
        test_fill_slots();
        test_hit_collide();
        test_overlap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
